// File: rtl/cpu.sv
// Minimal two-cycle 16-bit load/store processor: a unified instruction/data RAM,
// a 16-entry register file and a FETCH/EXEC sequencer with a HALTED sink state.

module cpu_ram #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    // Deliberately not reset so the preloaded program survives rst.
    logic [DATA_W-1:0] memory [0:MEM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            memory[addr] <= wdata;
        end
    end

    assign rdata = memory[addr];
endmodule

module cpu_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ra_addr,
    input  logic [3:0]        rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [3:0]        wa,
    input  logic [DATA_W-1:0] wd
);
    logic [DATA_W-1:0] registers [0:15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                registers[i] <= '0;
            end
        end else if (we) begin
            registers[wa] <= wd;
        end
    end

    assign ra_data = registers[ra_addr];
    assign rb_data = registers[rb_addr];
endmodule

module cpu #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst
);
    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDR  = 4'h2;
    localparam logic [3:0] OP_STR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BEQZ = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] ir_reg, ir_next;

    logic [3:0] op, rd, rs, rt;
    logic [7:0] imm8;
    logic [3:0] imm4;

    assign op   = ir_reg[15:12];
    assign rd   = ir_reg[11:8];
    assign rs   = ir_reg[7:4];
    assign rt   = ir_reg[3:0];
    assign imm8 = ir_reg[7:0];
    assign imm4 = ir_reg[3:0];

    logic [3:0]        rb_addr;
    logic [DATA_W-1:0] ra_data, rb_data;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wd;

    logic [ADDR_W-1:0] mem_addr, data_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic exec;
    assign exec = (state_reg == EXEC);

    // STR and BEQZ need R[rd] rather than R[rt] on the second read port.
    assign rb_addr   = (op == OP_STR || op == OP_BEQZ) ? rd : rt;
    assign data_addr = ra_data[ADDR_W-1:0] + ADDR_W'(imm4);
    assign mem_addr  = exec ? data_addr : pc_reg;
    assign mem_we    = exec && (op == OP_STR);

    cpu_ram #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) ram (
        .clk  (clk),
        .addr (mem_addr),
        .we   (mem_we),
        .wdata(rb_data),
        .rdata(mem_rdata)
    );

    cpu_regfile #(
        .DATA_W(DATA_W)
    ) register (
        .clk    (clk),
        .rst    (rst),
        .ra_addr(rs),
        .rb_addr(rb_addr),
        .ra_data(ra_data),
        .rb_data(rb_data),
        .we     (reg_we),
        .wa     (rd),
        .wd     (reg_wd)
    );

    always_comb begin
        reg_wd = '0;
        reg_we = 1'b0;
        case (op)
            OP_LDI: begin reg_wd = DATA_W'(imm8);             reg_we = 1'b1; end
            OP_LDR: begin reg_wd = mem_rdata;                 reg_we = 1'b1; end
            OP_ADD: begin reg_wd = ra_data + rb_data;         reg_we = 1'b1; end
            OP_SUB: begin reg_wd = ra_data - rb_data;         reg_we = 1'b1; end
            OP_AND: begin reg_wd = ra_data & rb_data;         reg_we = 1'b1; end
            OP_OR:  begin reg_wd = ra_data | rb_data;         reg_we = 1'b1; end
            OP_XOR: begin reg_wd = ra_data ^ rb_data;         reg_we = 1'b1; end
            OP_MOV: begin reg_wd = ra_data;                   reg_we = 1'b1; end
            OP_SHL: begin reg_wd = ra_data << rb_data[3:0];   reg_we = 1'b1; end
            OP_SHR: begin reg_wd = ra_data >> rb_data[3:0];   reg_we = 1'b1; end
            default: begin reg_wd = '0;                       reg_we = 1'b0; end
        endcase
        if (!exec) begin
            reg_we = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        case (state_reg)
            FETCH: begin
                ir_next    = mem_rdata;
                pc_next    = pc_reg + 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                state_next = FETCH;
                case (op)
                    OP_JMP:  pc_next = ADDR_W'(imm8);
                    OP_BEQZ: if (rb_data == '0) pc_next = ADDR_W'(imm8);
                    OP_HALT: state_next = HALTED;
                    default: pc_next = pc_reg;
                endcase
            end
            default: state_next = HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Directed-program bench for cpu: stimulus queues expected register/RAM/PC values,
// a negedge monitor pops and compares them against the design's internal state.

module tb_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    localparam int K_REG   = 0;
    localparam int K_MEM   = 1;
    localparam int K_PC    = 2;
    localparam int K_STATE = 3;
    localparam logic [15:0] ST_FETCH  = 16'd0;
    localparam logic [15:0] ST_HALTED = 16'd2;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    cpu dut (
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] probe(int kind, int idx);
        case (kind)
            K_REG:   return dut.register.registers[idx];
            K_MEM:   return dut.ram.memory[idx];
            K_PC:    return {8'h00, dut.pc_reg};
            default: return {14'h0, dut.state_reg};
        endcase
    endfunction

    // Monitor: drains pending expectations at each falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e   = sb_q.pop_front();
            act = probe(e.kind, e.idx);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %04h expected %04h", e.name, act, e.exp);
            end else begin
                $display("ok   %s = %04h", e.name, act);
            end
        end
    end

    task automatic push(string n, int k, int i, logic [15:0] v);
        exp_t e;
        e.name = n; e.kind = k; e.idx = i; e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic flush();
        int n = 0;
        while (sb_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL flush: %0d pending checks never compared", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic hold_reset_clear_ram();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) dut.ram.memory[i] = 16'h0000;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(string n, int max_cycles);
        bit done = 0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(posedge clk);
            #1;
            if ({14'h0, dut.state_reg} == ST_HALTED) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: no HALT within %0d cycles, got state %0d expected %0d",
                     n, max_cycles, dut.state_reg, ST_HALTED);
        end
    endtask

    initial begin
        // ---------------- LDR from preload ----------------
        hold_reset_clear_ram();
        dut.ram.memory[0] = 16'h2105;
        dut.ram.memory[1] = 16'hF000;
        dut.ram.memory[5] = 16'h00AB;
        repeat (2) @(posedge clk);
        push("reset_pc", K_PC, 0, 16'h0000);
        push("reset_state", K_STATE, 0, ST_FETCH);
        flush();
        release_reset();
        repeat (2) @(posedge clk);
        push("ldr_r1", K_REG, 1, 16'h00AB);
        push("ldr_r0", K_REG, 0, 16'h0000);
        push("ldr_r2", K_REG, 2, 16'h0000);
        push("ldr_pc", K_PC, 0, 16'h0001);
        flush();

        // ---------------- ALU program + HALT freeze ----------------
        hold_reset_clear_ram();
        begin
            logic [15:0] prog [0:12];
            prog = '{16'h1207, 16'h1303, 16'h4423, 16'h5532, 16'hA623, 16'h8723,
                     16'h6823, 16'h7923, 16'h9A20, 16'hBB43, 16'h1121, 16'h4111,
                     16'hF000};
            for (int i = 0; i < 13; i++) dut.ram.memory[i] = prog[i];
        end
        release_reset();
        run_to_halt("alu_halt", 60);
        repeat (20) @(posedge clk);
        push("add_r4", K_REG, 4, 16'h000A);
        push("sub_r5", K_REG, 5, 16'hFFFC);
        push("shl_r6", K_REG, 6, 16'h0038);
        push("xor_r7", K_REG, 7, 16'h0004);
        push("and_r8", K_REG, 8, 16'h0003);
        push("or_r9", K_REG, 9, 16'h0007);
        push("mov_r10", K_REG, 10, 16'h0007);
        push("shr_r11", K_REG, 11, 16'h0001);
        push("dbl_r1", K_REG, 1, 16'h0042);
        push("halt_pc", K_PC, 0, 16'h000D);
        push("halt_state", K_STATE, 0, ST_HALTED);
        flush();

        // ---------------- mid-EXEC reset ----------------
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) dut.ram.memory[i] = 16'h0000;
        dut.ram.memory[0]    = 16'h115A;
        dut.ram.memory[1]    = 16'h310F;
        dut.ram.memory[2]    = 16'h220F;
        dut.ram.memory[3]    = 16'h1420;
        dut.ram.memory[4]    = 16'h2340;
        dut.ram.memory[5]    = 16'h3306;
        dut.ram.memory[6]    = 16'hF000;
        dut.ram.memory[7]    = 16'h15FF;
        dut.ram.memory[8]    = 16'h2652;
        dut.ram.memory[9]    = 16'hF000;
        dut.ram.memory[8'h20] = 16'h1C77;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);  // fetch of LDI r1,0x5A; now in EXEC
        #2;
        rst = 1'b1;      // abandon the LDI before its write edge
        #1;
        push("midrst_pc", K_PC, 0, 16'h0000);
        push("midrst_r4", K_REG, 4, 16'h0000);
        push("midrst_r1", K_REG, 1, 16'h0000);
        push("midrst_ram0", K_MEM, 0, 16'h115A);
        push("midrst_state", K_STATE, 0, ST_FETCH);
        flush();

        // ---------------- STR/LDR, self-modifying store, address wrap ----------------
        release_reset();
        run_to_halt("mem_halt", 60);
        push("str_mem15", K_MEM, 15, 16'h005A);
        push("ldr_r2_fwd", K_REG, 2, 16'h005A);
        push("smc_mem6", K_MEM, 6, 16'h1C77);
        push("smc_r12", K_REG, 12, 16'h0077);
        push("wrap_ldr_r6", K_REG, 6, 16'h310F);
        push("mem_pc", K_PC, 0, 16'h000A);
        flush();

        // ---------------- control flow ----------------
        hold_reset_clear_ram();
        dut.ram.memory[8'h00] = 16'h1100;
        dut.ram.memory[8'h01] = 16'hD110;
        dut.ram.memory[8'h02] = 16'h1855;
        dut.ram.memory[8'h03] = 16'hF000;
        dut.ram.memory[8'h10] = 16'h1999;
        dut.ram.memory[8'h11] = 16'h1201;
        dut.ram.memory[8'h12] = 16'hD230;
        dut.ram.memory[8'h13] = 16'hC020;
        dut.ram.memory[8'h14] = 16'h1A11;
        dut.ram.memory[8'h20] = 16'hF000;
        release_reset();
        run_to_halt("ctl_halt", 60);
        push("beqz_r9", K_REG, 9, 16'h0099);
        push("skip_r8", K_REG, 8, 16'h0000);
        push("bnt_r2", K_REG, 2, 16'h0001);
        push("jmp_skip_r10", K_REG, 10, 16'h0000);
        push("ctl_pc", K_PC, 0, 16'h0021);
        flush();

        // ---------------- JMP to self ----------------
        hold_reset_clear_ram();
        dut.ram.memory[0] = 16'hC000;
        release_reset();
        repeat (40) @(posedge clk);
        push("jself_pc", K_PC, 0, 16'h0000);
        push("jself_state", K_STATE, 0, ST_FETCH);
        flush();

        // ---------------- PC wrap 0xFF -> 0x00 ----------------
        hold_reset_clear_ram();
        dut.ram.memory[8'h00] = 16'hD5FE;
        dut.ram.memory[8'h01] = 16'hF000;
        dut.ram.memory[8'hFE] = 16'h1501;
        dut.ram.memory[8'hFF] = 16'h0000;
        release_reset();
        run_to_halt("wrap_halt", 40);
        push("wrap_r5", K_REG, 5, 16'h0001);
        push("wrap_pc", K_PC, 0, 16'h0002);
        flush();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
